// File: rtl/irq_ctrl_wb.sv
// -----------------------------------------------------------------------------
// irq_ctrl_wb
//   Interrupt controller sitting between platform interrupt sources and the
//   Hornet core. External sources are synchronised, latched into a pending
//   vector, arbitrated (lowest index wins) and presented one at a time on
//   meip_o. Each claim is released by the core's irq_ack pulse and is followed
//   by a guaranteed one-cycle deassert gap. Fast sources are synchronised and
//   edge-latched straight onto fast_irq_o. An ack that does not retire an
//   meip claim clears the lowest-index pending fast bit instead.
//
// Ports
//   clk_i          in   1       core clock
//   reset_i        in   1       asynchronous, active-low reset
//   src_i          in   N_SRC   external interrupt requests (asynchronous)
//   src_en_i       in   N_SRC   per-source enable (masked sources still latch)
//   fast_src_i     in   N_FAST  fast interrupt requests (asynchronous)
//   irq_ack_i      in   1       one-cycle acknowledge pulse from the core
//   meip_o         out  1       machine external interrupt to the core
//   claim_id_o     out  ID_W    index of the source presented on meip_o
//   claim_valid_o  out  1       claim_id_o is meaningful
//   fast_irq_o     out  N_FAST  latched fast interrupt pending bits
//   pending_o      out  N_SRC   raw external pending vector (status)
// -----------------------------------------------------------------------------
module irq_ctrl_wb #(
  parameter int               N_SRC       = 8,
  parameter int               N_FAST      = 16,
  parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b1}},
  parameter int               SYNC_STAGES = 2,
  localparam int              ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_SRC-1:0]  src_i,
  input  logic [N_SRC-1:0]  src_en_i,
  input  logic [N_FAST-1:0] fast_src_i,
  input  logic              irq_ack_i,
  output logic              meip_o,
  output logic [ID_W-1:0]   claim_id_o,
  output logic              claim_valid_o,
  output logic [N_FAST-1:0] fast_irq_o,
  output logic [N_SRC-1:0]  pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers plus one history flop for edge detection
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0]  src_sync  [SYNC_STAGES];
  logic [N_FAST-1:0] fast_sync [SYNC_STAGES];
  logic [N_SRC-1:0]  src_hist;
  logic [N_FAST-1:0] fast_hist;

  // NOTE: every flop that holds state uses a non-blocking assignment, so all
  // stages of the chain update together on the edge instead of shooting
  // through in one cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: these arrays are small flop banks, not RAM, so they are cleared
      // on reset; a stale '1' would otherwise fake an edge after reset.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        src_sync[i]  <= '0;
        fast_sync[i] <= '0;
      end
      src_hist  <= '0;
      fast_hist <= '0;
    end else begin
      src_sync[0]  <= src_i;
      fast_sync[0] <= fast_src_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        src_sync[i]  <= src_sync[i-1];
        fast_sync[i] <= fast_sync[i-1];
      end
      src_hist  <= src_sync[SYNC_STAGES-1];
      fast_hist <= fast_sync[SYNC_STAGES-1];
    end
  end

  logic [N_SRC-1:0]  src_synced;
  logic [N_SRC-1:0]  src_rise;
  logic [N_FAST-1:0] fast_synced;
  logic [N_FAST-1:0] fast_rise;

  assign src_synced  = src_sync[SYNC_STAGES-1];
  assign fast_synced = fast_sync[SYNC_STAGES-1];
  assign src_rise    = src_synced & ~src_hist;
  assign fast_rise   = fast_synced & ~fast_hist;

  // ---------------------------------------------------------------------------
  // Arbitration, FSM next state and pending updates
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [ID_W-1:0]   claim_id_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_FAST-1:0] fast_q, fast_d;

  logic [N_SRC-1:0]  eligible;
  logic              any_eligible;
  logic [ID_W-1:0]   winner;
  logic              load_claim;
  logic              ack_meip;
  logic              ack_fast;
  logic [N_SRC-1:0]  src_clr;
  logic [N_FAST-1:0] fast_clr;

  assign eligible     = pending_q & src_en_i;
  assign any_eligible = |eligible;

  // An ack retires the meip claim only while one is being presented;
  // otherwise it falls through to the fast lines.
  assign ack_meip = irq_ack_i && (state_q == ST_ASSERT);
  assign ack_fast = irq_ack_i && (state_q != ST_ASSERT);

  always_comb begin
    // NOTE: defaults come first so every path assigns every signal and no
    // latch is inferred.
    winner     = '0;
    src_clr    = '0;
    fast_clr   = '0;
    load_claim = 1'b0;
    state_d    = state_q;

    // Scan downward so the lowest eligible index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end

    for (int i = 0; i < N_SRC; i++) begin
      src_clr[i] = ack_meip && (claim_id_q == ID_W'(i));
    end

    // x & -x isolates the lowest set bit; zero when nothing is pending.
    if (ack_fast) fast_clr = fast_q & (~fast_q + N_FAST'(1));

    unique case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          load_claim = 1'b1;
          state_d    = ST_ASSERT;
        end
      end
      // The claim stays frozen here regardless of new arrivals or enables.
      ST_ASSERT: if (ack_meip) state_d = ST_GAP;
      // Forces one deasserted cycle so the core sees a clean falling edge.
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Edge sources: a new rising edge is ORed in after the clear, so a set and
  // clear in the same cycle keeps the new edge. Level sources follow the
  // synced input but read 0 for the cycle their claim is acked.
  assign pending_d = (EDGE_MASK & ((pending_q & ~src_clr) | src_rise))
                   | (~EDGE_MASK & src_synced & ~src_clr);
  assign fast_d    = (fast_q & ~fast_clr) | fast_rise;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      claim_id_q <= '0;
      pending_q  <= '0;
      fast_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      fast_q    <= fast_d;
      if (load_claim) claim_id_q <= winner;
    end
  end

  // Outputs come straight from flops, so an async reset drops them at once.
  assign meip_o        = (state_q == ST_ASSERT);
  assign claim_valid_o = (state_q == ST_ASSERT);
  assign claim_id_o    = claim_id_q;
  assign fast_irq_o    = fast_q;
  assign pending_o     = pending_q;

endmodule

// File: tb/tb_irq_ctrl_wb.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl_wb
//   Directed bench for irq_ctrl_wb. One instance uses edge-latched sources
//   (default), a second uses level sources (EDGE_MASK = 8'h00). Inputs are
//   driven 1 ns after a rising edge and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_irq_ctrl_wb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  src, src_en, src_lvl;
  logic [15:0] fast;
  logic        ack, ack_lvl;

  logic        meip, valid, meip_lvl, valid_lvl;
  logic [2:0]  claim_id, claim_id_lvl;
  logic [15:0] fast_irq, fast_irq_lvl;
  logic [7:0]  pending, pending_lvl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  irq_ctrl_wb dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .src_i         (src),
    .src_en_i      (src_en),
    .fast_src_i    (fast),
    .irq_ack_i     (ack),
    .meip_o        (meip),
    .claim_id_o    (claim_id),
    .claim_valid_o (valid),
    .fast_irq_o    (fast_irq),
    .pending_o     (pending)
  );

  irq_ctrl_wb #(.EDGE_MASK(8'h00)) dut_lvl (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .src_i         (src_lvl),
    .src_en_i      (src_en),
    .fast_src_i    (fast),
    .irq_ack_i     (ack_lvl),
    .meip_o        (meip_lvl),
    .claim_id_o    (claim_id_lvl),
    .claim_valid_o (valid_lvl),
    .fast_irq_o    (fast_irq_lvl),
    .pending_o     (pending_lvl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
  endtask

  task automatic ack_lvl_pulse();
    ack_lvl = 1'b1;
    cycles(1);
    ack_lvl = 1'b0;
  endtask

  initial begin
    // 1. Reset with all sources high
    reset_i = 1'b0;
    src     = 8'hFF;
    src_lvl = 8'hFF;
    src_en  = 8'hFF;
    fast    = 16'h0000;
    ack     = 1'b0;
    ack_lvl = 1'b0;
    cycles(8);
    check("rst_meip",     meip,     0);
    check("rst_valid",    valid,    0);
    check("rst_fast",     fast_irq, 0);
    check("rst_pending",  pending,  0);
    check("rst_lvl_meip", meip_lvl, 0);
    src     = 8'h00;
    src_lvl = 8'h00;
    cycles(1);
    reset_i = 1'b1;
    cycles(3);

    // 2. Single edge on source 3: pending after 3 edges, meip after 4
    src = 8'h08;
    cycles(1);
    src = 8'h00;
    cycles(2);
    check("se_pending", pending, 8'h08);
    check("se_meip_lo", meip,    0);
    cycles(1);
    check("se_meip",  meip,     1);
    check("se_claim", claim_id, 3);
    check("se_valid", valid,    1);
    ack_pulse();
    check("se_ack_meip",    meip,    0);
    check("se_ack_valid",   valid,   0);
    check("se_ack_pending", pending, 0);
    cycles(1);
    check("se_gap_meip", meip, 0);
    cycles(1);
    check("se_idle_meip", meip, 0);

    // 3. Priority / freeze
    src = 8'h20;
    cycles(4);
    check("pf_meip5",  meip,     1);
    check("pf_claim5", claim_id, 5);
    src = 8'h22;
    cycles(4);
    check("pf_pending", pending,  8'h22);
    check("pf_frozen",  claim_id, 5);
    check("pf_meip",    meip,     1);
    ack_pulse();
    check("pf_ack_meip",    meip,    0);
    check("pf_ack_pending", pending, 8'h02);
    cycles(1);
    check("pf_gap_meip", meip, 0);
    cycles(1);
    check("pf_meip1",  meip,     1);
    check("pf_claim1", claim_id, 1);
    ack_pulse();
    src = 8'h00;
    cycles(3);
    check("pf_end_meip",    meip,    0);
    check("pf_end_pending", pending, 0);

    // 4. Level mode on source 2
    src_lvl = 8'h04;
    cycles(4);
    check("lv_pending", pending_lvl,  8'h04);
    check("lv_meip",    meip_lvl,     1);
    check("lv_claim",   claim_id_lvl, 2);
    ack_lvl_pulse();
    check("lv_ack1_meip",    meip_lvl,    0);
    check("lv_ack1_pending", pending_lvl, 0);
    cycles(1);
    check("lv_gap_meip",    meip_lvl,    0);
    check("lv_gap_pending", pending_lvl, 8'h04);
    cycles(1);
    check("lv_reassert1", meip_lvl, 1);
    ack_lvl_pulse();
    check("lv_ack2_meip", meip_lvl, 0);
    cycles(2);
    check("lv_reassert2", meip_lvl, 1);
    src_lvl = 8'h00;
    cycles(3);
    check("lv_drop_pending", pending_lvl, 0);
    check("lv_drop_meip",    meip_lvl,    1);
    ack_lvl_pulse();
    check("lv_ack3_meip", meip_lvl, 0);
    cycles(3);
    check("lv_stays_low", meip_lvl, 0);

    // 5. Fast ack routing with no meip claim
    fast = 16'h0024;
    cycles(2);
    check("fa_not_yet", fast_irq, 0);
    cycles(1);
    check("fa_latched", fast_irq, 16'h0024);
    ack_pulse();
    check("fa_ack1", fast_irq, 16'h0020);
    check("fa_meip", meip,     0);
    ack_pulse();
    check("fa_ack2", fast_irq, 16'h0000);
    ack_pulse();
    check("fa_ack_idle_fast",  fast_irq, 16'h0000);
    check("fa_ack_idle_meip",  meip,     0);
    check("fa_ack_idle_valid", valid,    0);
    fast = 16'h0000;
    cycles(3);

    // 5b. Ack during ASSERT leaves fast bits alone
    src = 8'h40;
    cycles(4);
    check("fb_meip",  meip,     1);
    check("fb_claim", claim_id, 6);
    fast = 16'h0024;
    cycles(3);
    check("fb_fast_latched", fast_irq, 16'h0024);
    check("fb_meip_held",    meip,     1);
    ack_pulse();
    check("fb_ack_meip", meip,     0);
    check("fb_ack_fast", fast_irq, 16'h0024);
    ack_pulse();
    check("fb_gap_ack_fast", fast_irq, 16'h0020);
    ack_pulse();
    check("fb_idle_ack_fast", fast_irq, 16'h0000);
    check("fb_idle_meip",     meip,     0);
    src  = 8'h00;
    fast = 16'h0000;
    cycles(3);

    // 6. Mask, enable, disable-while-claimed, mid-ASSERT reset
    src_en = 8'hEF;
    src    = 8'h10;
    cycles(1);
    src = 8'h00;
    cycles(3);
    check("mk_pending", pending, 8'h10);
    check("mk_meip",    meip,    0);
    cycles(2);
    check("mk_meip_still", meip, 0);
    src_en = 8'hFF;
    cycles(1);
    check("mk_en_meip",  meip,     1);
    check("mk_en_claim", claim_id, 4);
    src_en = 8'hEF;
    cycles(2);
    check("mk_dis_held", meip, 1);
    #3;
    reset_i = 1'b0;
    #1;
    check("mr_meip",    meip,     0);
    check("mr_valid",   valid,    0);
    check("mr_pending", pending,  0);
    check("mr_claim",   claim_id, 0);
    cycles(2);
    reset_i = 1'b1;
    src_en  = 8'hFF;
    cycles(2);
    check("mr_after_meip", meip, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
